lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_checker.sv | 100 ++++++++++
 tb/tb_lfsr_checker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// lfsr_checker: compares received words against a Galois LFSR reference sequence,
// and tracks lock/fail status with saturating match and error counters.
module lfsr_checker #(
    parameter int                    LFSR_WIDTH    = 8,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED     = LFSR_WIDTH'(1),
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS     = LFSR_WIDTH'('hB8),
    parameter int                    BITS_PER_WORD = 4,
    parameter int                    LOCK_COUNT    = 4,
    parameter int                    CNT_WIDTH     = 8,
    parameter bit                    HALT_ON_FAIL  = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [BITS_PER_WORD-1:0] in_data,
    output logic                     in_ready,
    output logic                     locked,
    output logic                     fail,
    output logic                     mismatch,
    output logic [CNT_WIDTH-1:0]     match_count,
    output logic [CNT_WIDTH-1:0]     error_count,
    output logic [1:0]               state_out
);
    localparam int RW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, LOCKED = 2'd2, FAIL = 2'd3} state_t;

    state_t                   r_state, w_state_nxt;
    logic [LFSR_WIDTH-1:0]    r_lfsr, w_lfsr_nxt;
    logic [BITS_PER_WORD-1:0] w_word;
    logic [RW-1:0]            r_run, w_run_nxt;
    logic [CNT_WIDTH-1:0]     r_match, r_err;
    logic                     r_mis, w_xfer, w_hit;

    assign in_ready    = !(HALT_ON_FAIL && r_state == FAIL);
    assign locked      = r_state == LOCKED;
    assign fail        = r_state == FAIL;
    assign mismatch    = r_mis;
    assign match_count = r_match;
    assign error_count = r_err;
    assign state_out   = r_state;

    // Unroll one word's worth of steps; bit k carries the output of step k.
    always_comb begin
        w_lfsr_nxt = r_lfsr;
        w_word     = '0;
        for (int k = 0; k < BITS_PER_WORD; k++) begin
            w_word[k]  = w_lfsr_nxt[0];
            w_lfsr_nxt = (w_lfsr_nxt >> 1) ^ (w_lfsr_nxt[0] ? LFSR_TAPS : '0);
        end
    end

    // IDLE behaves as CHECK with an empty run, so the first match already counts toward lock.
    always_comb begin
        w_xfer      = in_valid & in_ready;
        w_hit       = in_data == w_word;
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        if (w_xfer && (r_state == IDLE || r_state == CHECK)) begin
            w_run_nxt   = w_hit ? r_run + 1'b1 : '0;
            w_state_nxt = !w_hit ? r_state : (w_run_nxt >= RW'(LOCK_COUNT)) ? LOCKED : CHECK;
        end else if (w_xfer && r_state == LOCKED && !w_hit) begin
            w_state_nxt = FAIL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_lfsr  <= LFSR_SEED;
            r_run   <= '0;
            r_match <= '0;
            r_err   <= '0;
            r_mis   <= 1'b0;
        end else if (clear) begin
            r_state <= IDLE;
            r_lfsr  <= LFSR_SEED;
            r_run   <= '0;
            r_match <= '0;
            r_err   <= '0;
            r_mis   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_mis   <= w_xfer & ~w_hit;
            if (w_xfer)
                r_lfsr <= w_lfsr_nxt;
            if (w_xfer && w_hit && r_match != '1)
                r_match <= r_match + 1'b1;
            if (w_xfer && !w_hit && r_err != '1)
                r_err <= r_err + 1'b1;
        end
    end

    // A zero state would lock the LFSR at zero forever, which only a zero seed can cause.
    always @(posedge clk)
        if (!reset)
            assert (r_lfsr != '0);
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: two checker instances (halting 8-bit counters, non-halting 2-bit counters)
// driven in lockstep and compared against an arithmetic reference model.
module tb_lfsr_checker;
    logic       clk = 1'b0, reset = 1'b1, clear = 1'b0, in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       rdy0, lk0, fl0, mm0, rdy1, lk1, fl1, mm1;
    logic [7:0] mc0, ec0;
    logic [1:0] mc1, ec1, st0, st1;
    logic [7:0] o_mc[2], o_ec[2];
    logic [1:0] o_st[2];
    logic       o_rdy[2], o_lk[2], o_fl[2], o_mm[2];
    int n_cmp = 0, n_bad = 0;
    int m_lfsr[2], m_st[2], m_run[2], m_mc[2], m_ec[2], m_mis[2];
    bit halt[2] = '{1'b1, 1'b0};
    int sat[2]  = '{255, 3};

    always #5 clk = ~clk;

    lfsr_checker #(.HALT_ON_FAIL(1'b1), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .locked(lk0), .fail(fl0), .mismatch(mm0),
        .match_count(mc0), .error_count(ec0), .state_out(st0));

    lfsr_checker #(.HALT_ON_FAIL(1'b0), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .locked(lk1), .fail(fl1), .mismatch(mm1),
        .match_count(mc1), .error_count(ec1), .state_out(st1));

    always_comb begin
        o_mc[0] = mc0;  o_mc[1] = {6'b0, mc1};
        o_ec[0] = ec0;  o_ec[1] = {6'b0, ec1};
        o_st[0] = st0;  o_st[1] = st1;
        o_rdy[0] = rdy0; o_rdy[1] = rdy1;
        o_lk[0] = lk0;  o_lk[1] = lk1;
        o_fl[0] = fl0;  o_fl[1] = fl1;
        o_mm[0] = mm0;  o_mm[1] = mm1;
    end

    function automatic int exp_word(int s);
        int w = 0;
        for (int k = 0; k < 4; k++) begin
            w |= (s & 1) << k;
            s = (s & 1) ? ((s >> 1) ^ 'hB8) : (s >> 1);
        end
        return w;
    endfunction

    function automatic int adv(int s);
        for (int k = 0; k < 4; k++)
            s = (s & 1) ? ((s >> 1) ^ 'hB8) : (s >> 1);
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_lfsr[i] = 1; m_st[i] = 0; m_run[i] = 0; m_mc[i] = 0; m_ec[i] = 0; m_mis[i] = 0;
        end
    endtask

    task automatic cycle(input bit v, input int d, input bit c);
        bit hit;
        in_valid = v; in_data = 4'(d); clear = c;
        for (int i = 0; i < 2; i++) begin
            if (c) begin
                m_lfsr[i] = 1; m_st[i] = 0; m_run[i] = 0; m_mc[i] = 0; m_ec[i] = 0; m_mis[i] = 0;
            end else if (v && !(halt[i] && m_st[i] == 3)) begin
                hit = (d == exp_word(m_lfsr[i]));
                m_lfsr[i] = adv(m_lfsr[i]);
                m_mis[i] = hit ? 0 : 1;
                if (hit) begin
                    if (m_mc[i] < sat[i]) m_mc[i]++;
                    if (m_st[i] < 2) begin
                        m_run[i]++;
                        m_st[i] = (m_run[i] >= 4) ? 2 : 1;
                    end
                end else begin
                    if (m_ec[i] < sat[i]) m_ec[i]++;
                    if (m_st[i] == 1) m_run[i] = 0;
                    else if (m_st[i] == 2) m_st[i] = 3;
                end
            end else begin
                m_mis[i] = 0;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; model_reset();
        #2;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (o_st[i] !== 2'd0 || o_mc[i] !== 8'd0 || o_ec[i] !== 8'd0 || o_rdy[i] !== 1'b1 ||
                o_lk[i] !== 1'b0 || o_fl[i] !== 1'b0 || o_mm[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset dut%0d: st=%0d mc=%0d ec=%0d rdy=%b lk=%b fl=%b mm=%b, need 0/0/0/1/0/0/0",
                         i, o_st[i], o_mc[i], o_ec[i], o_rdy[i], o_lk[i], o_fl[i], o_mm[i]);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_lock_seq();
        cycle(1, 'h1, 0); cycle(1, 'h7, 0); cycle(1, 'h4, 0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (o_st[i] !== 2'd1 || o_mc[i] !== 8'd3 || o_ec[i] !== 8'd0) begin
                n_bad++;
                $display("FAIL three_words dut%0d: st=%0d mc=%0d ec=%0d, need 1/3/0", i, o_st[i], o_mc[i], o_ec[i]);
            end
        end
        cycle(1, 'hA, 0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (o_lk[i] !== 1'b1 || o_st[i] !== 2'd2 || o_mc[i] !== (i == 0 ? 8'd4 : 8'd3)) begin
                n_bad++;
                $display("FAIL lock dut%0d: lk=%b st=%0d mc=%0d, need 1/2/%0d", i, o_lk[i], o_st[i], o_mc[i], i == 0 ? 4 : 3);
            end
        end
        cycle(1, exp_word(m_lfsr[0]), 0);
        n_cmp++;
        if (o_mc[0] !== 8'd5 || o_mc[1] !== 8'd3) begin
            n_bad++;
            $display("FAIL saturate: mc0=%0d mc1=%0d, need 5/3", o_mc[0], o_mc[1]);
        end
    endtask

    task automatic test_fail();
        int d = (exp_word(m_lfsr[0]) == 15) ? 0 : 15;
        cycle(1, d, 0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (o_mm[i] !== 1'b1 || o_fl[i] !== 1'b1 || o_ec[i] !== 8'd1 || o_st[i] !== 2'd3 || o_lk[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL fail_entry dut%0d: mm=%b fl=%b ec=%0d st=%0d lk=%b, need 1/1/1/3/0",
                         i, o_mm[i], o_fl[i], o_ec[i], o_st[i], o_lk[i]);
            end
        end
        n_cmp++;
        if (o_rdy[0] !== 1'b0 || o_rdy[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL halt_ready: rdy0=%b rdy1=%b, need 0/1", o_rdy[0], o_rdy[1]);
        end
        cycle(0, 0, 0);
        n_cmp++;
        if (o_mm[0] !== 1'b0 || o_mm[1] !== 1'b0 || o_fl[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL pulse_width: mm0=%b mm1=%b fl0=%b, need 0/0/1", o_mm[0], o_mm[1], o_fl[0]);
        end
        cycle(1, 15 - exp_word(m_lfsr[0]), 0);
        n_cmp++;
        if (o_ec[0] !== 8'd1 || o_mm[0] !== 1'b0 || o_ec[1] !== 8'd2 || o_fl[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL halted_xfer: ec0=%0d mm0=%b ec1=%0d fl1=%b, need 1/0/2/1", o_ec[0], o_mm[0], o_ec[1], o_fl[1]);
        end
    endtask

    task automatic test_first_mismatch();
        cycle(0, 0, 1);
        cycle(1, 'h0, 0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (o_st[i] !== 2'd0 || o_ec[i] !== 8'd1 || o_mc[i] !== 8'd0 || o_mm[i] !== 1'b1) begin
                n_bad++;
                $display("FAIL idle_miss dut%0d: st=%0d ec=%0d mc=%0d mm=%b, need 0/1/0/1", i, o_st[i], o_ec[i], o_mc[i], o_mm[i]);
            end
        end
        cycle(1, 'h7, 0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (o_st[i] !== 2'd1 || o_mc[i] !== 8'd1) begin
                n_bad++;
                $display("FAIL idle_to_check dut%0d: st=%0d mc=%0d, need 1/1", i, o_st[i], o_mc[i]);
            end
        end
    endtask

    task automatic test_clear_locked();
        cycle(1, 'h4, 0); cycle(1, 'hA, 0); cycle(1, exp_word(m_lfsr[0]), 0);
        n_cmp++;
        if (o_lk[0] !== 1'b1 || o_lk[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL relock: lk0=%b lk1=%b, need 1/1", o_lk[0], o_lk[1]);
        end
        cycle(1, exp_word(m_lfsr[0]), 1);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (o_st[i] !== 2'd0 || o_mc[i] !== 8'd0 || o_ec[i] !== 8'd0 || o_mm[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL clear_xfer dut%0d: st=%0d mc=%0d ec=%0d mm=%b, need 0/0/0/0", i, o_st[i], o_mc[i], o_ec[i], o_mm[i]);
            end
        end
        cycle(1, 'h1, 0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (o_st[i] !== 2'd1 || o_mc[i] !== 8'd1 || o_ec[i] !== 8'd0) begin
                n_bad++;
                $display("FAIL clear_reseed dut%0d: st=%0d mc=%0d ec=%0d, need 1/1/0", i, o_st[i], o_mc[i], o_ec[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, 'h7, 0);
        in_valid = 1'b1; in_data = 4'(exp_word(m_lfsr[0]));
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (o_st[i] !== 2'd0 || o_mc[i] !== 8'd0 || o_rdy[i] !== 1'b1 || o_lk[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL async_reset dut%0d: st=%0d mc=%0d rdy=%b lk=%b, need 0/0/1/0", i, o_st[i], o_mc[i], o_rdy[i], o_lk[i]);
            end
        end
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        cycle(1, 'h1, 0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (o_st[i] !== 2'd1 || o_mc[i] !== 8'd1 || o_ec[i] !== 8'd0) begin
                n_bad++;
                $display("FAIL reset_reseed dut%0d: st=%0d mc=%0d ec=%0d, need 1/1/0", i, o_st[i], o_mc[i], o_ec[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            int d = ($urandom_range(9, 0) < 8) ? exp_word(m_lfsr[$urandom_range(1, 0)]) : int'($urandom_range(15, 0));
            cycle($urandom_range(3, 0) != 0, d, $urandom_range(49, 0) == 0);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (o_st[i] !== 2'(m_st[i]) || o_mc[i] !== 8'(m_mc[i]) || o_ec[i] !== 8'(m_ec[i]) ||
                    o_mm[i] !== 1'(m_mis[i]) || o_lk[i] !== (m_st[i] == 2) || o_fl[i] !== (m_st[i] == 3) ||
                    o_rdy[i] !== !(halt[i] && m_st[i] == 3)) begin
                    n_bad++;
                    $display("FAIL random[%0d] dut%0d: st=%0d mc=%0d ec=%0d mm=%b lk=%b fl=%b rdy=%b, need st=%0d mc=%0d ec=%0d mm=%0d",
                             n, i, o_st[i], o_mc[i], o_ec[i], o_mm[i], o_lk[i], o_fl[i], o_rdy[i],
                             m_st[i], m_mc[i], m_ec[i], m_mis[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_seq();
        test_fail();
        test_first_mismatch();
        test_clear_locked();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
